// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter side, master = requester/ALU side.
interface alu_share_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) ();
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [CW-1:0] req0_ctrl;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [CW-1:0] req1_ctrl;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_out;
  logic          alu_ovf;
  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [DW-1:0] rsp0_data;
  logic          rsp0_ovf;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [DW-1:0] rsp1_data;
  logic          rsp1_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_out, alu_ovf,
    output rsp0_valid, rsp0_data, rsp0_ovf,
    output rsp1_valid, rsp1_data, rsp1_ovf,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_out, alu_ovf,
    input  rsp0_valid, rsp0_data, rsp0_ovf,
    input  rsp1_valid, rsp1_data, rsp1_ovf,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional ALU_OVF_TRAP_EN: suppress overflowed results and add a sticky ovf_trap output.
module alu_share_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned CW       = 6,
  parameter int unsigned ADD_CODE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef ALU_OVF_TRAP_EN
  output logic                ovf_trap,
`endif
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          any_valid;
  logic          win;
  logic          rsp_hs;
  logic [DW-1:0] rsp_data_c;
`ifdef ALU_OVF_TRAP_EN
  logic          trap_q, trap_d;
`endif

  // last_grant resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
`ifdef ALU_OVF_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    win       = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    rsp_hs    = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Next state and register updates
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
`ifdef ALU_OVF_TRAP_EN
    trap_d       = trap_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = win;
          a_d     = win ? bus.req1_a    : bus.req0_a;
          b_d     = win ? bus.req1_b    : bus.req0_b;
          ctrl_d  = win ? bus.req1_ctrl : bus.req0_ctrl;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        ovf_d    = bus.alu_ovf & (ctrl_q == CW'(ADD_CODE));
`ifdef ALU_OVF_TRAP_EN
        trap_d   = trap_q | ovf_d;
`endif
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only for the IDLE winner, response only toward the granted port
  always_comb begin
`ifdef ALU_OVF_TRAP_EN
    rsp_data_c = ovf_q ? '0 : result_q;
`else
    rsp_data_c = result_q;
`endif
    bus.req0_ready = (state_q == IDLE) & bus.req0_valid & ~win;
    bus.req1_ready = (state_q == IDLE) & bus.req1_valid &  win;
    bus.rsp0_valid = (state_q == RESP) & ~grant_q;
    bus.rsp1_valid = (state_q == RESP) &  grant_q;
    bus.rsp0_data  = bus.rsp0_valid ? rsp_data_c : '0;
    bus.rsp1_data  = bus.rsp1_valid ? rsp_data_c : '0;
    bus.rsp0_ovf   = bus.rsp0_valid & ovf_q;
    bus.rsp1_ovf   = bus.rsp1_valid & ovf_q;
    bus.alu_a      = a_q;
    bus.alu_b      = b_q;
    bus.alu_ctrl   = ctrl_q;
  end

`ifdef ALU_OVF_TRAP_EN
  assign ovf_trap = trap_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU model.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  logic ovf_force;
  int   errors;
  int   checks;
`ifdef ALU_OVF_TRAP_EN
  logic ovf_trap;
`endif

  alu_share_arbiter_if #(.DW(32), .CW(6)) bus ();

  alu_share_arbiter #(.DW(32), .CW(6), .ADD_CODE(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef ALU_OVF_TRAP_EN
    .ovf_trap(ovf_trap),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD 16, SUB 34, AND 36, SLT 42
  logic [32:0] sum33;
  always_comb begin
    sum33 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    case (bus.alu_ctrl)
      6'd16:   bus.alu_out = sum33[31:0];
      6'd34:   bus.alu_out = bus.alu_a - bus.alu_b;
      6'd36:   bus.alu_out = bus.alu_a & bus.alu_b;
      6'd42:   bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_out = 32'd0;
    endcase
    bus.alu_ovf = ((bus.alu_ctrl == 6'd16) & sum33[32]) | ovf_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] c);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE on port p, including response handshake
  task automatic do_op(input string name, input int p, input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic frc, input logic [31:0] exp_d,
                       input logic exp_o);
    set_req(p, 1'b1, a, b, c);
    ovf_force = frc;
    #1;
    chk({name, " ready"}, 64'(p == 0 ? bus.req0_ready : bus.req1_ready), 64'd1);
    chk({name, " other ready"}, 64'(p == 0 ? bus.req1_ready : bus.req0_ready), 64'd0);
    step();
    set_req(p, 1'b0, 32'd0, 32'd0, 6'd0);
    chk({name, " alu_a"}, 64'(bus.alu_a), 64'(a));
    chk({name, " alu_ctrl"}, 64'(bus.alu_ctrl), 64'(c));
    chk({name, " exec no rsp"}, 64'(bus.rsp0_valid | bus.rsp1_valid), 64'd0);
    step();
    chk({name, " rsp valid"}, 64'(p == 0 ? bus.rsp0_valid : bus.rsp1_valid), 64'd1);
    chk({name, " other rsp"}, 64'(p == 0 ? bus.rsp1_valid : bus.rsp0_valid), 64'd0);
    chk({name, " data"}, 64'(p == 0 ? bus.rsp0_data : bus.rsp1_data), 64'(exp_d));
    chk({name, " ovf"}, 64'(p == 0 ? bus.rsp0_ovf : bus.rsp1_ovf), 64'(exp_o));
    chk({name, " other data"}, 64'(p == 0 ? bus.rsp1_data : bus.rsp0_data), 64'd0);
    if (p == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    ovf_force = 1'b0;
    chk({name, " back idle"}, 64'(bus.rsp0_valid | bus.rsp1_valid), 64'd0);
  endtask

  typedef struct {
    string       name;
    int          port;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        frc;
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs[5];

  initial begin
    errors = 0;
    checks = 0;
    ovf_force = 1'b0;
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    vecs[0] = '{"and",     0, 6'd36, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 1'b0};
`ifdef ALU_OVF_TRAP_EN
    vecs[1] = '{"add_ovf", 1, 6'd16, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000000, 1'b1};
`else
    vecs[1] = '{"add_ovf", 1, 6'd16, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 1'b1};
`endif
    vecs[2] = '{"slt_mask", 0, 6'd42, 32'd5, 32'd9, 1'b1, 32'd1, 1'b0};
    vecs[3] = '{"sub",     1, 6'd34, 32'd10, 32'd3, 1'b0, 32'd7, 1'b0};
    vecs[4] = '{"add",     0, 6'd16, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0};

    #3;
    chk("rst rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    chk("rst alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("rst alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst rsp_data", 64'({bus.rsp0_data, bus.rsp1_data}), 64'd0);
`ifdef ALU_OVF_TRAP_EN
    chk("rst ovf_trap", 64'(ovf_trap), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].name, vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b,
            vecs[i].frc, vecs[i].exp_d, vecs[i].exp_o);
`ifdef ALU_OVF_TRAP_EN
      chk("ovf_trap sticky", 64'(ovf_trap), 64'(i >= 1));
`endif
    end

    // Backpressure on port 0 while port 1 waits
    set_req(0, 1'b1, 32'h12345678, 32'hFF00FF00, 6'd36);
    #1;
    chk("bp ready0", 64'(bus.req0_ready), 64'd1);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b1, 32'd100, 32'd23, 6'd16);
    #1;
    chk("bp exec ready1", 64'(bus.req1_ready), 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
      chk("bp rsp0_data", 64'(bus.rsp0_data), 64'h12005600);
      chk("bp ready1", 64'(bus.req1_ready), 64'd0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp hs ready1", 64'(bus.req1_ready), 64'd0);
    step();
    bus.rsp0_ready = 1'b0;
    chk("bp idle ready1", 64'(bus.req1_ready), 64'd1);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    step();
    chk("bp rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    chk("bp rsp1_data", 64'(bus.rsp1_data), 64'd123);
    bus.rsp1_ready = 1'b1;
    step();
    bus.rsp1_ready = 1'b0;

    // Make port 0 the last grant so the post-reset tie proves last_grant was restored
    do_op("pre_rst", 0, 6'd36, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'h0F0F0000, 1'b0);

    // Asynchronous reset while a port 1 response is pending
    set_req(1, 1'b1, 32'd40, 32'd2, 6'd16);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    step();
    chk("mid rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    chk("mid rst rsp1_data", 64'(bus.rsp1_data), 64'd0);
    chk("mid rst alu ops", 64'({bus.alu_a, bus.alu_b}), 64'd0);
    chk("mid rst alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
`ifdef ALU_OVF_TRAP_EN
    chk("mid rst ovf_trap", 64'(ovf_trap), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Tie-break: port 0 first, then port 1, then port 0 again
    set_req(0, 1'b1, 32'd1, 32'd2, 6'd16);
    set_req(1, 1'b1, 32'd10, 32'd3, 6'd34);
    #1;
    chk("tie1 ready0", 64'(bus.req0_ready), 64'd1);
    chk("tie1 ready1", 64'(bus.req1_ready), 64'd0);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    step();
    chk("tie1 rsp0_data", 64'(bus.rsp0_data), 64'd3);
    chk("tie1 rsp ready1", 64'(bus.req1_ready), 64'd0);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;
    chk("tie2 ready1", 64'(bus.req1_ready), 64'd1);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    step();
    chk("tie2 rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    chk("tie2 rsp1_data", 64'(bus.rsp1_data), 64'd7);
    bus.rsp1_ready = 1'b1;
    step();
    bus.rsp1_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd2, 6'd16);
    set_req(1, 1'b1, 32'd10, 32'd3, 6'd34);
    #1;
    chk("tie3 ready0", 64'(bus.req0_ready), 64'd1);
    chk("tie3 ready1", 64'(bus.req1_ready), 64'd0);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0);
    step();
    chk("tie3 rsp0_data", 64'(bus.rsp0_data), 64'd3);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
